// File: rtl/carry_skip_pkg.sv
// Shared sizing helpers for the carry-skip adder family: block count and tail-block width.
package carry_skip_pkg;

    function automatic int unsigned num_blocks(input int unsigned n, input int unsigned bs);
        return (n + bs - 1) / bs;
    endfunction

    // Tail block takes the leftover bits, or a full block when N divides evenly.
    function automatic int unsigned last_block_width(input int unsigned n, input int unsigned bs);
        return ((n % bs) == 0) ? bs : (n % bs);
    endfunction

endpackage

// File: rtl/pipelined_carry_skip_adder_if.sv
// Valid/ready operand and result bus of the pipelined carry-skip adder.
interface pipelined_carry_skip_adder_if #(
    parameter int unsigned N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/csa_block.sv
// One combinational carry-skip block: ripple sum plus a block-propagate bypass of the carry.
module csa_block #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    logic       p;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
        // All bits propagating: the block carry-in passes straight through.
        p    = &(a ^ b);
        cout = p ? cin : c[W];
    end
endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Add/subtract pipeline evaluating one carry-skip block per stage, LSB block first.
module pipelined_carry_skip_adder
    import carry_skip_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pipelined_carry_skip_adder_if.slave bus
);
    localparam int unsigned NB     = num_blocks(N, BLOCK_SIZE);
    localparam int unsigned LAST_W = last_block_width(N, BLOCK_SIZE);

    // Stage-k inputs: element 0 is the bus, element k+1 is stage k's register.
    logic [N-1:0] a_i   [NB];
    logic [N-1:0] b_i   [NB];
    logic [N-1:0] s_i   [NB];
    logic         c_i   [NB];
    logic         sub_i [NB];
    logic         v_i   [NB];

    logic         advance;
    logic [N-1:0] sum_r;
    logic         cout_r;
    logic         ovf_r;
    logic         valid_r;

    assign advance      = !valid_r || bus.out_ready;
    assign bus.in_ready = advance;

    // Subtraction forces the initial carry to 1 and ignores cin.
    assign a_i[0]   = bus.a;
    assign b_i[0]   = bus.b;
    assign s_i[0]   = '0;
    assign c_i[0]   = bus.sub | bus.cin;
    assign sub_i[0] = bus.sub;
    assign v_i[0]   = bus.in_valid;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        localparam int unsigned LO      = k * BLOCK_SIZE;
        localparam bit          IS_LAST = (k == NB - 1);
        localparam int unsigned W       = IS_LAST ? LAST_W : BLOCK_SIZE;

        logic [N-1:0] b_eff;
        logic [N-1:0] s_nxt;
        logic [W-1:0] blk_sum;
        logic         blk_cout;

        assign b_eff = sub_i[k] ? ~b_i[k] : b_i[k];

        csa_block #(.W(W)) u_blk (
            .a    (W'(a_i[k] >> LO)),
            .b    (W'(b_eff >> LO)),
            .cin  (c_i[k]),
            .sum  (blk_sum),
            .cout (blk_cout)
        );

        // Upper sum bits are still zero here, so OR merges this block in.
        assign s_nxt = s_i[k] | (N'(blk_sum) << LO);

        if (!IS_LAST) begin : g_mid
            logic [N-1:0] a_q, b_q, s_q;
            logic         c_q, sub_q, v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                    v_q   <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_i[k];
                    b_q   <= b_i[k];
                    s_q   <= s_nxt;
                    c_q   <= blk_cout;
                    sub_q <= sub_i[k];
                    v_q   <= v_i[k];
                end
            end

            assign a_i[k+1]   = a_q;
            assign b_i[k+1]   = b_q;
            assign s_i[k+1]   = s_q;
            assign c_i[k+1]   = c_q;
            assign sub_i[k+1] = sub_q;
            assign v_i[k+1]   = v_q;
        end else begin : g_last
            // Carry into the MSB is recovered as a ^ b' ^ sum at bit N-1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_r   <= '0;
                    cout_r  <= 1'b0;
                    ovf_r   <= 1'b0;
                    valid_r <= 1'b0;
                end else if (advance) begin
                    sum_r   <= s_nxt;
                    cout_r  <= blk_cout;
                    ovf_r   <= a_i[k][N-1] ^ b_eff[N-1] ^ s_nxt[N-1] ^ blk_cout;
                    valid_r <= v_i[k];
                end
            end
        end
    end

    assign bus.out_valid = valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: doc/pipelined_carry_skip_adder.md
PIPELINED_CARRY_SKIP_ADDER -- requirements
Module: pipelined_carry_skip_adder

Interface
REQ-001 Parameter N, default 16, operand width in bits (N >= 1).
REQ-002 Parameter BLOCK_SIZE, default 4, carry-skip block width in bits (BLOCK_SIZE >= 1).
REQ-003 The module SHALL have exactly one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-007 in_ready  output  1  pipeline accepts the operand set this cycle.
REQ-008 a  input  N  operand A.
REQ-009 b  input  N  operand B.
REQ-010 cin  input  1  carry-in, used when sub=0.
REQ-011 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a+~b+1, cin ignored).
REQ-012 out_valid  output  1  result present on sum, cout, overflow.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 sum  output  N  result bits.
REQ-015 cout  output  1  carry-out of bit N-1; for sub, 1 means no borrow.
REQ-016 overflow  output  1  signed two's-complement overflow of the selected operation.

Function
REQ-017 NUM_BLOCKS SHALL equal ceil(N/BLOCK_SIZE); the last block SHALL cover the remaining N mod BLOCK_SIZE bits when that value is nonzero.
REQ-018 The pipeline SHALL have NUM_BLOCKS register stages, with one skip block evaluated per stage (LSB block in stage 0) and the carry registered between stages.
REQ-019 Each block SHALL compute propagate P = AND of (a_i XOR b'_i) over its bits and a ripple carry; block carry-out SHALL be cin_block when P=1, else the ripple carry.
REQ-020 Each stage SHALL carry forward the not-yet-summed operand bits, the completed sum bits, the carry, and the sub flag, together with its own valid bit.
REQ-021 Latency SHALL be NUM_BLOCKS cycles from the accepting edge (in_valid and in_ready) to out_valid, given no stall.
REQ-022 Advance SHALL be asserted when out_ready=1 or out_valid=0; all stages SHALL load only on advance, and in_ready SHALL equal advance.
REQ-023 While advance=0, every stage register and the outputs sum, cout, overflow and out_valid SHALL hold their values.
REQ-024 When a transfer occurs with in_valid=0, stage 0 valid SHALL load 0 (bubble); bubbles SHALL propagate and SHALL NOT produce out_valid.
REQ-025 Throughput SHALL be one result per cycle when out_ready stays high; in_valid and out_ready in the same cycle SHALL both complete.
REQ-026 overflow SHALL equal (carry into MSB) XOR cout; for N=1 it SHALL equal cin_into_bit0 XOR cout.
REQ-027 sum, cout and overflow SHALL be don't-care when out_valid=0 but SHALL be driven deterministically (no X after reset).

Reset
REQ-028 rst_n low SHALL clear all stage valid bits, out_valid, sum, cout and overflow to 0 asynchronously, regardless of clk.
REQ-029 Reset mid-operation SHALL discard all in-flight results; the first out_valid after reset release SHALL be for an operand set accepted after release.
REQ-030 in_ready SHALL be 1 during and immediately after reset, because out_valid=0.

Structure
REQ-031 A shared header carry_skip_pkg SHALL hold the NUM_BLOCKS computation and the last-block width function, for reuse by carry_skip_adder benches.
REQ-032 One combinational sub-module, csa_block (parameter W; ports a, b, cin, sum, cout), SHALL be instantiated once per stage through a generate loop.

Verification (N=8, BLOCK_SIZE=4, latency 2 unless noted)
REQ-033 a=0xFF, b=0x01, cin=0, sub=0, out_ready=1 -> two cycles later sum=0x00, cout=1, overflow=0 (full skip chain).
REQ-034 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; then sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, overflow=0.
REQ-035 Back-to-back issue of 0x10+0x20, then 0x30+0x40 with out_ready=0 for 3 cycles -> out_valid held with sum=0x30, in_ready=0 throughout; after release -> sum=0x30, then sum=0x70, each seen exactly once.
REQ-036 Assert rst_n=0 mid-stream with 2 results in flight -> out_valid=0 immediately; no stale results appear after release.
REQ-037 N=1, BLOCK_SIZE=4, a=1, b=1, cin=1 -> one cycle later sum=1, cout=1; exhaustively check all 8 input combinations plus sub=1.
REQ-038 N=10, BLOCK_SIZE=4 (3 stages, last block 2 bits): random 1000 operand sets with random out_ready -> results match a+b+cin in order, with latency 3 when unstalled.
